mod_exp_ctrl: RTL

MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

---
 rtl/mod_exp_ctrl_if.sv | 26 ++
 rtl/mod_exp_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl_if.sv
// Engine-side bus between the modular-exponentiation controller and the
// Montgomery product (mon_prod) engine.
interface mod_exp_ctrl_if #(
    parameter int bitLen     = 64,
    parameter int countWidth = 4
);
    logic                  mp_start;
    logic [bitLen-1:0]     mp_A;
    logic [bitLen-1:0]     mp_B;
    logic [bitLen-1:0]     mp_M;
    logic [countWidth-1:0] mp_num_words;
    logic                  mp_stop;
    logic [bitLen-1:0]     mp_P;

    // Controller side: issues operations and waits for the product.
    modport master (
        output mp_start, mp_A, mp_B, mp_M, mp_num_words,
        input  mp_stop, mp_P
    );

    // Engine side: receives operations and returns the product.
    modport slave (
        input  mp_start, mp_A, mp_B, mp_M, mp_num_words,
        output mp_stop, mp_P
    );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation sequencer: base^exp mod M computed left-to-right
// with Montgomery products issued to an external mon_prod engine.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; last result/err held
// TO_BASE   | bm = MonPro(base, r2); even M aborts here with err
// TO_ONE    | x  = MonPro(1, r2), Montgomery form of 1
// SCAN      | skip leading zeros of exp, one bit per cycle
// SQUARE    | x  = MonPro(x, x)
// MULT      | x  = MonPro(x, bm), only for a 1 bit
// FROM_MONT | result = MonPro(x, 1)
// FINISH    | done pulse, back to IDLE
//
// Engine states run two phases: ISSUE (one cycle, mp_start high) and WAIT.
module mod_exp_ctrl #(
    parameter int bitLen     = 64,
    parameter int expLen     = 16,
    parameter int countWidth = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [bitLen-1:0]     base_i,
    input  logic [bitLen-1:0]     m_i,
    input  logic [bitLen-1:0]     r2_i,
    input  logic [expLen-1:0]     exp_i,
    input  logic [countWidth-1:0] num_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [bitLen-1:0]     result_o,
    mod_exp_ctrl_if.master        mp
);

    // One extra bit so that decrementing past bit 0 lands in a value with
    // the MSB set; that is the end-of-exponent marker.
    localparam int IdxW = $clog2(expLen) + 1;

    typedef enum logic [2:0] {
        IDLE, SCAN, TO_BASE, TO_ONE, SQUARE, MULT, FROM_MONT, FINISH
    } state_t;

    typedef enum logic {ISSUE, WAIT} phase_t;

    state_t                state_q, state_d;
    phase_t                phase_q, phase_d;
    logic                  low_seen_q, low_seen_d;
    logic [bitLen-1:0]     base_q, m_q, r2_q;
    logic [expLen-1:0]     exp_q;
    logic [countWidth-1:0] nw_q;
    logic [bitLen-1:0]     x_q, x_d;
    logic [bitLen-1:0]     bm_q, bm_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic                  err_q, err_d;
    logic [bitLen-1:0]     result_q, result_d;
    logic                  load;

    logic                  engine_st;
    logic                  abort;
    logic                  op_done;
    logic                  cur_bit;
    logic [IdxW-1:0]       idx_dec;
    logic [bitLen-1:0]     op_a, op_b;

    assign engine_st = (state_q == TO_BASE) || (state_q == TO_ONE) ||
                       (state_q == SQUARE)  || (state_q == MULT)   ||
                       (state_q == FROM_MONT);
    // An even modulus is rejected before the first operation goes out.
    assign abort     = (state_q == TO_BASE) && !m_q[0];
    // Completion needs a low level seen first, so a stop still high from
    // the previous operation is never mistaken for this one finishing.
    assign op_done   = engine_st && (phase_q == WAIT) && low_seen_q && mp.mp_stop;
    assign cur_bit   = exp_q[idx_q[IdxW-2:0]];
    assign idx_dec   = idx_q - IdxW'(1);

    assign mp.mp_start     = engine_st && (phase_q == ISSUE) && !abort;
    assign mp.mp_A         = op_a;
    assign mp.mp_B         = op_b;
    assign mp.mp_M         = m_q;
    assign mp.mp_num_words = nw_q;

    assign busy_o   = (state_q != IDLE) && (state_q != FINISH);
    assign done_o   = (state_q == FINISH);
    assign err_o    = err_q;
    assign result_o = result_q;

    // Operand selection; inputs only change on completion, so they stay
    // stable for the whole operation.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            TO_BASE:   begin op_a = base_q;          op_b = r2_q;             end
            TO_ONE:    begin op_a = bitLen'(1);      op_b = r2_q;             end
            SQUARE:    begin op_a = x_q;             op_b = x_q;              end
            MULT:      begin op_a = x_q;             op_b = bm_q;             end
            FROM_MONT: begin op_a = x_q;             op_b = bitLen'(1);       end
            default:   begin op_a = '0;              op_b = '0;               end
        endcase
    end

    // Next-state logic: engine handshake phases and exponent walk.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        low_seen_d = low_seen_q;
        x_d        = x_q;
        bm_d       = bm_q;
        idx_d      = idx_q;
        err_d      = err_q;
        result_d   = result_q;
        load       = 1'b0;

        if (engine_st) begin
            if (phase_q == ISSUE) begin
                if (!abort) begin
                    phase_d    = WAIT;
                    low_seen_d = 1'b0;
                end
            end else if (!low_seen_q && !mp.mp_stop) begin
                low_seen_d = 1'b1;
            end
        end
        if (op_done) begin
            phase_d = ISSUE;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    err_d   = 1'b0;
                    idx_d   = IdxW'(expLen - 1);
                    phase_d = ISSUE;
                    state_d = TO_BASE;
                end
            end
            TO_BASE: begin
                if (abort) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = FINISH;
                end else if (op_done) begin
                    bm_d    = mp.mp_P;
                    state_d = TO_ONE;
                end
            end
            TO_ONE: begin
                if (op_done) begin
                    x_d     = mp.mp_P;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (idx_q[IdxW-1]) begin
                    state_d = FROM_MONT;
                end else if (cur_bit) begin
                    state_d = SQUARE;
                end else begin
                    idx_d = idx_dec;
                end
            end
            SQUARE: begin
                if (op_done) begin
                    x_d = mp.mp_P;
                    if (cur_bit) begin
                        state_d = MULT;
                    end else begin
                        idx_d   = idx_dec;
                        state_d = idx_dec[IdxW-1] ? FROM_MONT : SQUARE;
                    end
                end
            end
            MULT: begin
                if (op_done) begin
                    x_d     = mp.mp_P;
                    idx_d   = idx_dec;
                    state_d = idx_dec[IdxW-1] ? FROM_MONT : SQUARE;
                end
            end
            FROM_MONT: begin
                if (op_done) begin
                    result_d = mp.mp_P;
                    state_d  = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= ISSUE;
            low_seen_q <= 1'b0;
            base_q     <= '0;
            m_q        <= '0;
            r2_q       <= '0;
            exp_q      <= '0;
            nw_q       <= '0;
            x_q        <= '0;
            bm_q       <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            low_seen_q <= low_seen_d;
            x_q        <= x_d;
            bm_q       <= bm_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            result_q   <= result_d;
            if (load) begin
                base_q <= base_i;
                m_q    <= m_i;
                r2_q   <= r2_i;
                exp_q  <= exp_i;
                nw_q   <= num_words_i;
            end
        end
    end

endmodule
